dual_issue_buffer: RTL and testbench

DUAL_ISSUE_BUFFER -- requirements
Module: dual_issue_buffer

---
 rtl/dual_issue_buffer.sv | 169 ++++++++++++++++
 tb/tb_dual_issue_buffer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dual_issue_buffer.sv
// dual_issue_buffer
//   Circular instruction buffer between fetch and a two-wide decode stage.
//   Fetch pushes up to two instructions per cycle. Decode pops one instruction
//   on the master slot, or two when the second is a simple ALU op that is safe
//   to pair with the first.
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   in_valid/pc/inst_1, _2   fetched pair (slot 1 older, slot 2 younger)
//   in_ready                 pair accepted at the next edge (space for two)
//   stall                    decode stalled, nothing dequeues
//   flush                    redirect, every entry and any same-cycle push dropped
//   out_valid/pc/inst_1, _2  master and slave decode slots (combinational)
//   count                    number of occupied entries
module dual_issue_buffer #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid_1,
  input  logic [31:0] in_pc_1,
  input  logic [31:0] in_inst_1,
  input  logic        in_valid_2,
  input  logic [31:0] in_pc_2,
  input  logic [31:0] in_inst_2,
  output logic        in_ready,
  input  logic        stall,
  input  logic        flush,
  output logic        out_valid_1,
  output logic [31:0] out_pc_1,
  output logic [31:0] out_inst_1,
  output logic        out_valid_2,
  output logic [31:0] out_pc_2,
  output logic [31:0] out_inst_2,
  output logic [3:0]  count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Space for a full pair is required before accepting anything.
  localparam logic [3:0] CAP_C = 4'(DEPTH - 2);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLT   = 6'b101010;

  // Instructions the slave pipe can execute: add/sub/and/or/slt and addi.
  function automatic logic is_slave_legal(input logic [31:0] inst);
    logic legal_s;
    legal_s = 1'b0;
    case (inst[31:26])
      OP_RTYPE: begin
        case (inst[5:0])
          FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: legal_s = 1'b1;
          default:                               legal_s = 1'b0;
        endcase
      end
      OP_ADDI: legal_s = 1'b1;
      default: legal_s = 1'b0;
    endcase
    return legal_s;
  endfunction

  // Destination register; 0 stands for "none", since writes to $0 never hazard.
  function automatic logic [4:0] dest_reg(input logic [31:0] inst);
    logic [4:0] dest_s;
    case (inst[31:26])
      OP_RTYPE:            dest_s = inst[15:11];
      OP_SW, OP_BEQ, OP_J: dest_s = 5'd0;
      default:             dest_s = inst[20:16];
    endcase
    return dest_s;
  endfunction

  logic [31:0]   pc_mem_r   [DEPTH];
  logic [31:0]   inst_mem_r [DEPTH];
  logic [AW-1:0] head_r;
  logic [AW-1:0] tail_r;
  logic [3:0]    count_r;

  logic [AW-1:0] head1_s;
  logic [AW-1:0] tail1_s;
  logic [31:0]   head_inst_s;
  logic [31:0]   next_inst_s;
  logic [4:0]    head_dest_s;
  logic          hazard_s;
  logic          head_branch_s;
  logic          push1_s;
  logic          push2_s;
  logic [1:0]    push_cnt_s;
  logic [1:0]    pop_cnt_s;

  assign head1_s = head_r + AW'(1);
  assign tail1_s = tail_r + AW'(1);
  assign count   = count_r;

  // Pairing decision and output slot mux from the two head entries.
  always_comb begin
    head_inst_s   = inst_mem_r[head_r];
    next_inst_s   = inst_mem_r[head1_s];
    head_dest_s   = dest_reg(head_inst_s);
    head_branch_s = (head_inst_s[31:26] == OP_BEQ) || (head_inst_s[31:26] == OP_J);
    // rt of an I-type slave is its destination, covered by the WAW term.
    hazard_s = (head_dest_s != 5'd0) &&
               ((head_dest_s == next_inst_s[25:21]) ||
                ((next_inst_s[31:26] == OP_RTYPE) && (head_dest_s == next_inst_s[20:16])) ||
                (head_dest_s == dest_reg(next_inst_s)));

    out_valid_1 = (count_r != 4'd0);
    out_valid_2 = (count_r >= 4'd2) && is_slave_legal(next_inst_s) &&
                  !head_branch_s && !hazard_s;
    out_pc_1    = out_valid_1 ? pc_mem_r[head_r]    : 32'd0;
    out_inst_1  = out_valid_1 ? head_inst_s         : 32'd0;
    out_pc_2    = out_valid_2 ? pc_mem_r[head1_s]   : 32'd0;
    out_inst_2  = out_valid_2 ? next_inst_s         : 32'd0;
  end

  // Push/pop amounts; in_ready looks only at the current occupancy.
  always_comb begin
    in_ready   = (count_r <= CAP_C);
    push1_s    = in_ready && in_valid_1;
    push2_s    = push1_s && in_valid_2;
    push_cnt_s = {1'b0, push1_s} + {1'b0, push2_s};
    if (stall || flush) begin
      pop_cnt_s = 2'd0;
    end else if (out_valid_2) begin
      pop_cnt_s = 2'd2;
    end else if (out_valid_1) begin
      pop_cnt_s = 2'd1;
    end else begin
      pop_cnt_s = 2'd0;
    end
  end

  // Pointer and occupancy update; flush discards everything including this push.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= 4'd0;
    end else if (flush) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= 4'd0;
    end else begin
      head_r  <= head_r + AW'(pop_cnt_s);
      tail_r  <= tail_r + AW'(push_cnt_s);
      count_r <= count_r + {2'b00, push_cnt_s} - {2'b00, pop_cnt_s};
    end
  end

  // Entry storage; slots outside head..tail are don't-care so no reset is needed.
  always_ff @(posedge clk) begin
    if (push1_s) begin
      pc_mem_r[tail_r]   <= in_pc_1;
      inst_mem_r[tail_r] <= in_inst_1;
    end
    if (push2_s) begin
      pc_mem_r[tail1_s]   <= in_pc_2;
      inst_mem_r[tail1_s] <= in_inst_2;
    end
  end

endmodule

// File: tb/tb_dual_issue_buffer.sv
module tb_dual_issue_buffer;

  logic        clk = 1'b0;
  logic        rst, stall, flush;
  logic        in_valid_1, in_valid_2, in_ready;
  logic [31:0] in_pc_1, in_inst_1, in_pc_2, in_inst_2;
  logic        out_valid_1, out_valid_2;
  logic [31:0] out_pc_1, out_inst_1, out_pc_2, out_inst_2;
  logic [3:0]  count;

  always #5 clk = ~clk;

  dual_issue_buffer #(.DEPTH(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid_1(in_valid_1), .in_pc_1(in_pc_1), .in_inst_1(in_inst_1),
    .in_valid_2(in_valid_2), .in_pc_2(in_pc_2), .in_inst_2(in_inst_2),
    .in_ready(in_ready), .stall(stall), .flush(flush),
    .out_valid_1(out_valid_1), .out_pc_1(out_pc_1), .out_inst_1(out_inst_1),
    .out_valid_2(out_valid_2), .out_pc_2(out_pc_2), .out_inst_2(out_inst_2),
    .count(count)
  );

  typedef struct packed {
    logic [31:0] pc1;
    logic [31:0] inst1;
    logic        v2;
    logic [31:0] pc2;
    logic [31:0] inst2;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_got, mon_want;
  int  checks = 0;
  int  failures = 0;

  localparam logic [5:0] ADD = 6'h20, SUB = 6'h22, AND_ = 6'h24, OR_ = 6'h25;
  localparam logic [5:0] SLT = 6'h2a, NOR_ = 6'h27;
  localparam logic [5:0] ADDI = 6'h08, LW = 6'h23, SW = 6'h2b, BEQ = 6'h04, JOP = 6'h02;

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'b000000, rs, rt, rd, 5'b00000, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic exp_single(input logic [31:0] pc, input logic [31:0] inst);
    exp_q.push_back({pc, inst, 1'b0, 32'h0, 32'h0});
  endtask

  task automatic exp_dual(input logic [31:0] pc1, input logic [31:0] i1,
                          input logic [31:0] pc2, input logic [31:0] i2);
    exp_q.push_back({pc1, i1, 1'b1, pc2, i2});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v1, input logic [31:0] pc1, input logic [31:0] i1,
                       input logic v2, input logic [31:0] pc2, input logic [31:0] i2);
    in_valid_1 = v1; in_pc_1 = pc1; in_inst_1 = i1;
    in_valid_2 = v2; in_pc_2 = pc2; in_inst_2 = i2;
  endtask

  task automatic idle_in();
    in_valid_1 = 1'b0;
    in_valid_2 = 1'b0;
  endtask

  // Monitor: every dequeue (valid head, no stall/flush) must match the next expected issue.
  always @(negedge clk) begin
    if (!rst && !flush && !stall && out_valid_1) begin
      mon_got = {out_pc_1, out_inst_1, out_valid_2, out_pc_2, out_inst_2};
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_issue: got pc1=0x%08h v2=%0b pc2=0x%08h, none expected",
                 out_pc_1, out_valid_2, out_pc_2);
      end else begin
        mon_want = exp_q.pop_front();
        if (mon_got !== mon_want) begin
          failures++;
          $display("FAIL issue: got pc1=%h inst1=%h v2=%0b pc2=%h inst2=%h expected pc1=%h inst1=%h v2=%0b pc2=%h inst2=%h",
                   mon_got.pc1, mon_got.inst1, mon_got.v2, mon_got.pc2, mon_got.inst2,
                   mon_want.pc1, mon_want.inst1, mon_want.v2, mon_want.pc2, mon_want.inst2);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  logic [31:0] tbl_i1 [12];
  logic [31:0] tbl_i2 [12];
  logic        tbl_dual [12];
  logic [31:0] pc;
  logic [31:0] jinst;
  int          n;

  initial begin
    jinst = {JOP, 26'h10};
    tbl_i1 = '{rtype(2,3,1,ADD), itype(ADDI,0,8,16'd5), rtype(2,3,1,ADD), itype(BEQ,1,2,16'd4),
               itype(ADDI,0,5,16'd1), rtype(1,2,3,ADD), rtype(1,2,0,ADD), itype(SW,5,4,16'd0),
               jinst, rtype(2,3,1,ADD), itype(ADDI,3,2,16'd7), rtype(2,3,1,ADD)};
    tbl_i2 = '{rtype(5,6,4,OR_), rtype(8,8,9,ADD), itype(LW,5,4,16'd0), rtype(8,9,7,ADD),
               rtype(1,5,6,SUB), itype(ADDI,4,3,16'd1), rtype(0,0,3,AND_), rtype(5,6,4,SLT),
               rtype(2,3,1,ADD), rtype(5,6,4,NOR_), itype(ADDI,5,4,16'd2), itype(ADDI,1,7,16'd3)};
    tbl_dual = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);

    // Reset held two cycles, then released
    tick(); tick();
    rst = 1'b0;
    check("rst_count", 32'(count), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid_1", 32'(out_valid_1), 32'd0);
    check("rst_out_valid_2", 32'(out_valid_2), 32'd0);
    check("rst_out_pc_1", out_pc_1, 32'd0);
    check("rst_out_inst_2", out_inst_2, 32'd0);

    // Pairing table: independent, RAW, illegal slave, branch head, WAW, $0 dest, sw head, j head
    for (int k = 0; k < 12; k++) begin
      pc = 32'h100 + 32'(k) * 32'h10;
      drive(1'b1, pc, tbl_i1[k], 1'b1, pc + 32'h4, tbl_i2[k]);
      if (tbl_dual[k]) begin
        exp_dual(pc, tbl_i1[k], pc + 32'h4, tbl_i2[k]);
      end else begin
        exp_single(pc, tbl_i1[k]);
        exp_single(pc + 32'h4, tbl_i2[k]);
      end
      tick();
      idle_in();
      check($sformatf("pair%0d_out_valid_2", k), 32'(out_valid_2), 32'(tbl_dual[k]));
      check($sformatf("pair%0d_count", k), 32'(count), 32'd2);
      check($sformatf("pair%0d_out_pc_1", k), out_pc_1, pc);
      check($sformatf("pair%0d_out_pc_2", k), out_pc_2, tbl_dual[k] ? pc + 32'h4 : 32'h0);
      tick();
      check($sformatf("pair%0d_count_after_pop", k), 32'(count), tbl_dual[k] ? 32'd0 : 32'd1);
      if (!tbl_dual[k]) begin
        check($sformatf("pair%0d_master_pc", k), out_pc_1, pc + 32'h4);
      end
      tick();
      check($sformatf("pair%0d_drained", k), 32'(count), 32'd0);
    end

    // Fill under stall, overflow pair dropped, then wrap while draining
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pc = 32'h200 + 32'(i) * 32'h8;
      drive(1'b1, pc, itype(LW,0,5'(2*i+1),16'd0), 1'b1, pc + 32'h4, itype(LW,0,5'(2*i+2),16'd0));
      exp_single(pc, itype(LW,0,5'(2*i+1),16'd0));
      exp_single(pc + 32'h4, itype(LW,0,5'(2*i+2),16'd0));
      tick();
    end
    idle_in();
    check("full_count", 32'(count), 32'd8);
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("full_head_pc", out_pc_1, 32'h200);
    drive(1'b1, 32'h220, itype(LW,0,5'd20,16'd0), 1'b1, 32'h224, itype(LW,0,5'd21,16'd0));
    tick();
    idle_in();
    check("overflow_dropped_count", 32'(count), 32'd8);
    tick();
    check("stall_hold_pc", out_pc_1, 32'h200);
    stall = 1'b0;
    for (int j = 0; j < 6; j++) begin
      pc = 32'h240 + 32'(j) * 32'h8;
      drive(1'b1, pc, itype(LW,0,5'(j+1),16'd0), 1'b1, pc + 32'h4, itype(LW,0,5'(j+9),16'd0));
      n = 0;
      while (!in_ready && n < 20) begin
        tick();
        n++;
      end
      check($sformatf("accept_wait_%0d", j), 32'(n < 20), 32'd1);
      exp_single(pc, itype(LW,0,5'(j+1),16'd0));
      exp_single(pc + 32'h4, itype(LW,0,5'(j+9),16'd0));
      tick();
    end
    idle_in();
    n = 0;
    while (count != 4'd0 && n < 40) begin
      tick();
      n++;
    end
    check("wrap_drain_count", 32'(count), 32'd0);
    check("wrap_scoreboard_empty", 32'(exp_q.size()), 32'd0);

    // Flush with five entries queued and a pair arriving in the same cycle
    stall = 1'b1;
    drive(1'b1, 32'h400, itype(LW,0,5'd1,16'd0), 1'b1, 32'h404, itype(LW,0,5'd2,16'd0));
    tick();
    drive(1'b1, 32'h408, itype(LW,0,5'd3,16'd0), 1'b1, 32'h40c, itype(LW,0,5'd4,16'd0));
    tick();
    drive(1'b1, 32'h410, itype(LW,0,5'd5,16'd0), 1'b0, 32'h0, 32'h0);
    tick();
    idle_in();
    check("pre_flush_count", 32'(count), 32'd5);
    flush = 1'b1;
    drive(1'b1, 32'h418, itype(LW,0,5'd6,16'd0), 1'b1, 32'h41c, itype(LW,0,5'd7,16'd0));
    tick();
    flush = 1'b0;
    idle_in();
    check("flush_count", 32'(count), 32'd0);
    check("flush_out_valid_1", 32'(out_valid_1), 32'd0);
    check("flush_in_ready", 32'(in_ready), 32'd1);
    check("flush_out_pc_1", out_pc_1, 32'd0);
    stall = 1'b0;
    tick(); tick();
    check("flush_pair_absent", 32'(count), 32'd0);

    // Normal operation resumes after the flush
    drive(1'b1, 32'h500, rtype(2,3,1,ADD), 1'b1, 32'h504, rtype(5,6,4,OR_));
    exp_dual(32'h500, rtype(2,3,1,ADD), 32'h504, rtype(5,6,4,OR_));
    tick();
    idle_in();
    check("post_flush_out_valid_2", 32'(out_valid_2), 32'd1);
    tick();
    check("post_flush_count", 32'(count), 32'd0);
    check("final_scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
